csr_exec: RTL and testbench

CSR_EXEC -- requirements
Module: csr_exec

---
 rtl/csr_pkg.sv | 33 +++
 rtl/csr_alu.sv | 21 ++
 rtl/csr_exec.sv | 140 ++++++++++++++
 tb/tb_csr_exec.sv | 294 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/csr_pkg.sv
// Shared encodings for the CSR/system-instruction executor: opcodes, CSR
// addresses, trap causes and the controller state enum.
package csr_pkg;

  localparam logic [2:0] OP_CSRRW = 3'b000;
  localparam logic [2:0] OP_CSRRS = 3'b001;
  localparam logic [2:0] OP_CSRRC = 3'b010;
  localparam logic [2:0] OP_ECALL = 3'b011;
  localparam logic [2:0] OP_MRET  = 3'b100;

  localparam logic [11:0] CSR_MSTATUS = 12'h300;
  localparam logic [11:0] CSR_MTVEC   = 12'h305;
  localparam logic [11:0] CSR_MEPC    = 12'h341;
  localparam logic [11:0] CSR_MCAUSE  = 12'h342;

  localparam int unsigned CAUSE_ILLEGAL = 2;
  localparam int unsigned CAUSE_ECALL   = 11;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_READ  = 3'd1,
    S_WRITE = 3'd2,
    S_TRAP  = 3'd3,
    S_MRET  = 3'd4,
    S_RESP  = 3'd5
  } state_e;

  // True for the read-modify-write CSR instructions.
  function automatic logic is_csr_op(input logic [2:0] op);
    return (op == OP_CSRRW) || (op == OP_CSRRS) || (op == OP_CSRRC);
  endfunction

endpackage

// File: rtl/csr_alu.sv
// Combinational write-value generator for CSRRW / CSRRS / CSRRC.
module csr_alu
  import csr_pkg::*;
#(
  parameter int DATA_LEN = 32
) (
  input  logic [2:0]          i_op,
  input  logic [DATA_LEN-1:0] i_old,
  input  logic [DATA_LEN-1:0] i_src,
  output logic [DATA_LEN-1:0] o_wdata
);

  always_comb begin
    case (i_op)
      OP_CSRRS: o_wdata = i_old | i_src;
      OP_CSRRC: o_wdata = i_old & ~i_src;
      default:  o_wdata = i_src;
    endcase
  end

endmodule

// File: rtl/csr_exec.sv
// CSR / ECALL / MRET executor: one request at a time, sequenced through a
// small FSM that strobes the CSR file and returns rd data or a redirect.
module csr_exec
  import csr_pkg::*;
#(
  parameter int DATA_LEN = 32
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                req_valid,
  output logic                req_ready,
  input  logic [2:0]          req_op,
  input  logic [11:0]         req_addr,
  input  logic [DATA_LEN-1:0] req_src,
  input  logic                req_src_zero,
  input  logic [DATA_LEN-1:0] req_pc,
  output logic                resp_valid,
  input  logic                resp_ready,
  output logic [DATA_LEN-1:0] resp_rdata,
  output logic                resp_redirect,
  output logic [DATA_LEN-1:0] resp_target,
  output logic                csr_ren,
  output logic                csr_wen,
  output logic                csr_unusual_flag,
  output logic [11:0]         csr_addr,
  output logic [DATA_LEN-1:0] csr_wdata,
  output logic [DATA_LEN-1:0] csr_cause,
  output logic [DATA_LEN-1:0] csr_pc,
  input  logic [DATA_LEN-1:0] csr_rdata
);

  state_e              r_state;
  state_e              w_next;
  logic [2:0]          r_op;
  logic [11:0]         r_addr;
  logic [DATA_LEN-1:0] r_src;
  logic                r_src_zero;
  logic [DATA_LEN-1:0] r_pc;
  logic [DATA_LEN-1:0] r_old;
  logic [DATA_LEN-1:0] r_target;
  logic [DATA_LEN-1:0] w_alu_wdata;
  logic                w_accept;
  logic                w_is_csr;

  assign w_accept = req_valid && (r_state == S_IDLE);
  assign w_is_csr = is_csr_op(r_op);

  csr_alu #(.DATA_LEN(DATA_LEN)) u_alu (
    .i_op    (r_op),
    .i_old   (r_old),
    .i_src   (r_src),
    .o_wdata (w_alu_wdata)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state    <= S_IDLE;
      r_op       <= '0;
      r_addr     <= '0;
      r_src      <= '0;
      r_src_zero <= 1'b0;
      r_pc       <= '0;
      r_old      <= '0;
      r_target   <= '0;
    end else begin
      r_state <= w_next;
      if (w_accept) begin
        r_op       <= req_op;
        r_addr     <= req_addr;
        r_src      <= req_src;
        r_src_zero <= req_src_zero;
        r_pc       <= req_pc;
        r_old      <= '0;
        r_target   <= '0;
      end
      if (r_state == S_READ) r_old <= csr_rdata;
      // csr_rdata carries mtvec while trapping and mepc while in MRET.
      if ((r_state == S_TRAP) || (r_state == S_MRET)) r_target <= csr_rdata;
    end
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE: begin
        if (w_accept) begin
          if (is_csr_op(req_op))       w_next = S_READ;
          else if (req_op == OP_MRET)  w_next = S_MRET;
          else                         w_next = S_TRAP;
        end
      end
      S_READ:  w_next = S_WRITE;
      S_WRITE: w_next = S_RESP;
      S_TRAP:  w_next = S_RESP;
      S_MRET:  w_next = S_RESP;
      S_RESP:  if (resp_ready) w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  always_comb begin
    csr_ren          = 1'b0;
    csr_wen          = 1'b0;
    csr_unusual_flag = 1'b0;
    csr_addr         = '0;
    csr_wdata        = '0;
    csr_cause        = '0;
    csr_pc           = '0;
    case (r_state)
      S_READ: begin
        csr_ren  = 1'b1;
        csr_addr = r_addr;
      end
      S_WRITE: begin
        csr_addr  = r_addr;
        csr_wdata = w_alu_wdata;
        // Set/clear with a zero operand must not write (read-only CSR safe).
        csr_wen   = !(r_src_zero && (r_op != OP_CSRRW));
      end
      S_TRAP: begin
        csr_unusual_flag = 1'b1;
        csr_pc           = r_pc;
        csr_cause        = (r_op == OP_ECALL) ? DATA_LEN'(CAUSE_ECALL)
                                              : DATA_LEN'(CAUSE_ILLEGAL);
      end
      S_MRET: begin
        csr_ren  = 1'b1;
        csr_addr = CSR_MEPC;
      end
      default: ;
    endcase
  end

  assign req_ready     = (r_state == S_IDLE);
  assign resp_valid    = (r_state == S_RESP);
  assign resp_redirect = resp_valid && !w_is_csr;
  assign resp_rdata    = (resp_valid && w_is_csr) ? r_old : '0;
  assign resp_target   = resp_redirect ? r_target : '0;

endmodule

// File: tb/tb_csr_exec.sv
// Directed bench for csr_exec with a behavioural CSR file and a response
// scoreboard checked by an independent monitor.
module tb_csr_exec;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic [2:0]  req_op = '0;
  logic [11:0] req_addr = '0;
  logic [31:0] req_src = '0;
  logic        req_src_zero = 1'b0;
  logic [31:0] req_pc = '0;
  logic        resp_valid;
  logic        resp_ready = 1'b1;
  logic [31:0] resp_rdata;
  logic        resp_redirect;
  logic [31:0] resp_target;
  logic        csr_ren, csr_wen, csr_unusual_flag;
  logic [11:0] csr_addr;
  logic [31:0] csr_wdata, csr_cause, csr_pc, csr_rdata;

  csr_exec #(.DATA_LEN(32)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_op(req_op),
    .req_addr(req_addr), .req_src(req_src), .req_src_zero(req_src_zero),
    .req_pc(req_pc),
    .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_rdata(resp_rdata),
    .resp_redirect(resp_redirect), .resp_target(resp_target),
    .csr_ren(csr_ren), .csr_wen(csr_wen), .csr_unusual_flag(csr_unusual_flag),
    .csr_addr(csr_addr), .csr_wdata(csr_wdata), .csr_cause(csr_cause),
    .csr_pc(csr_pc), .csr_rdata(csr_rdata)
  );

  always #5 clk = ~clk;

  // Behavioural CSR file.
  logic [31:0] m_mstatus = 32'h0000_1800;
  logic [31:0] m_mtvec   = 32'h0;
  logic [31:0] m_mepc    = 32'h0;
  logic [31:0] m_mcause  = 32'h0;

  function automatic logic [31:0] m_read(input logic [11:0] a);
    case (a)
      12'h300: return m_mstatus;
      12'h305: return m_mtvec;
      12'h341: return m_mepc;
      12'h342: return m_mcause;
      default: return 32'h0;
    endcase
  endfunction

  always_comb begin
    csr_rdata = 32'h0;
    if (csr_unusual_flag) csr_rdata = m_mtvec;
    else if (csr_ren)     csr_rdata = m_read(csr_addr);
  end

  int          n_checks = 0;
  int          n_bad = 0;
  int          cyc = 0;
  int          acc_cyc = 0;
  int          n_wen = 0;
  int          n_unu = 0;
  int          pops = 0;
  int          pushes = 0;
  logic [31:0] last_wdata = '0;
  logic [11:0] last_waddr = '0;
  logic [31:0] last_cause = '0;

  typedef struct {
    logic [31:0] rdata;
    logic        redir;
    logic [31:0] target;
    int          lat;
  } exp_t;
  exp_t q[$];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  // CSR file update and strobe accounting, sampled mid-cycle.
  initial forever begin
    @(negedge clk);
    if (!rst) begin
      if (csr_wen) begin
        n_wen++;
        last_wdata = csr_wdata;
        last_waddr = csr_addr;
        case (csr_addr)
          12'h300: m_mstatus = csr_wdata;
          12'h305: m_mtvec   = csr_wdata;
          12'h341: m_mepc    = csr_wdata;
          12'h342: m_mcause  = csr_wdata;
          default: ;
        endcase
      end
      if (csr_unusual_flag) begin
        n_unu++;
        last_cause = csr_cause;
        m_mepc     = csr_pc;
        m_mcause   = csr_cause;
      end
    end
  end

  // Response monitor: checks latency on first sight, fields on handshake.
  initial begin
    bit seen = 0;
    forever begin
      @(negedge clk);
      if (rst) seen = 0;
      else if (resp_valid) begin
        if (q.size() == 0) begin
          n_checks++;
          n_bad++;
          $display("FAIL unexpected_resp: got resp_valid=1 expected no response");
          @(posedge clk);
        end else begin
          if (!seen) begin
            seen = 1;
            chk("latency", 64'(cyc - acc_cyc + 1), 64'(q[0].lat));
          end
          if (resp_ready) begin
            exp_t e;
            e = q.pop_front();
            chk("resp_rdata", resp_rdata, e.rdata);
            chk("resp_redirect", resp_redirect, e.redir);
            chk("resp_target", resp_target, e.target);
            pops++;
            seen = 0;
          end
        end
      end
    end
  end

  task automatic issue(input logic [2:0] op, input logic [11:0] addr,
                       input logic [31:0] src, input logic zero, input logic [31:0] pc);
    int i;
    for (i = 0; i < 20; i++) begin
      if (req_ready) break;
      @(posedge clk); #1;
    end
    if (!req_ready) chk("req_ready_wait", req_ready, 1'b1);
    req_valid = 1'b1; req_op = op; req_addr = addr;
    req_src = src; req_src_zero = zero; req_pc = pc;
    @(posedge clk); #1;
    acc_cyc = cyc;
    req_valid = 1'b0;
  endtask

  task automatic wait_done();
    for (int i = 0; i < 30; i++) begin
      if (pops >= pushes) break;
      @(posedge clk); #1;
    end
    if (pops < pushes) begin
      n_checks++;
      n_bad++;
      $display("FAIL resp_timeout: got %0d responses expected %0d", pops, pushes);
      q.delete();
      pops = pushes;
    end
  endtask

  task automatic run_op(input logic [2:0] op, input logic [11:0] addr,
                        input logic [31:0] src, input logic zero, input logic [31:0] pc,
                        input logic [31:0] e_rdata, input logic e_redir, input logic [31:0] e_target);
    exp_t e;
    e.rdata = e_rdata; e.redir = e_redir; e.target = e_target;
    e.lat = (op <= 3'b010) ? 3 : 2;
    q.push_back(e);
    pushes++;
    issue(op, addr, src, zero, pc);
    wait_done();
  endtask

  initial begin
    int w0, u0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_req_ready", req_ready, 1'b1);
    chk("rst_resp_valid", resp_valid, 1'b0);
    chk("rst_csr_strobes", {csr_ren, csr_wen, csr_unusual_flag}, 3'b000);
    chk("rst_resp_rdata", resp_rdata, 32'h0);
    rst = 1'b0;
    @(posedge clk); #1;

    // CSRRW mtvec
    w0 = n_wen;
    run_op(3'b000, 12'h305, 32'h8000_0100, 1'b0, 32'h0, 32'h0, 1'b0, 32'h0);
    chk("rw_wen_pulse", 64'(n_wen - w0), 64'd1);
    chk("rw_wdata", last_wdata, 32'h8000_0100);
    run_op(3'b001, 12'h305, 32'h0, 1'b1, 32'h0, 32'h8000_0100, 1'b0, 32'h0);

    // CSRRS mstatus: zero operand first (no write), then set bit 3
    w0 = n_wen;
    run_op(3'b001, 12'h300, 32'h0, 1'b1, 32'h0, 32'h1800, 1'b0, 32'h0);
    chk("rs_zero_no_wen", 64'(n_wen - w0), 64'd0);
    run_op(3'b001, 12'h300, 32'h8, 1'b0, 32'h0, 32'h1800, 1'b0, 32'h0);
    chk("rs_wen_pulse", 64'(n_wen - w0), 64'd1);
    chk("rs_wdata", last_wdata, 32'h1808);

    // ECALL
    u0 = n_unu; w0 = n_wen;
    run_op(3'b011, 12'h0, 32'h0, 1'b0, 32'h8000_0040, 32'h0, 1'b1, 32'h8000_0100);
    chk("ecall_flag_pulse", 64'(n_unu - u0), 64'd1);
    chk("ecall_cause", last_cause, 32'd11);
    chk("ecall_mepc", m_mepc, 32'h8000_0040);
    chk("ecall_no_wen", 64'(n_wen - w0), 64'd0);

    // MRET to 0x80000044
    run_op(3'b000, 12'h341, 32'h8000_0044, 1'b0, 32'h0, 32'h8000_0040, 1'b0, 32'h0);
    u0 = n_unu; w0 = n_wen;
    run_op(3'b100, 12'h0, 32'h0, 1'b0, 32'h8000_0090, 32'h0, 1'b1, 32'h8000_0044);
    chk("mret_no_wen", 64'(n_wen - w0), 64'd0);
    chk("mret_no_flag", 64'(n_unu - u0), 64'd0);

    // Illegal op
    u0 = n_unu;
    run_op(3'b111, 12'h0, 32'h0, 1'b0, 32'h8000_0050, 32'h0, 1'b1, 32'h8000_0100);
    chk("illegal_flag_pulse", 64'(n_unu - u0), 64'd1);
    chk("illegal_cause", last_cause, 32'd2);
    chk("illegal_mepc", m_mepc, 32'h8000_0050);

    // CSRRC and an unimplemented address
    run_op(3'b010, 12'h300, 32'h800, 1'b0, 32'h0, 32'h1808, 1'b0, 32'h0);
    chk("rc_wdata", last_wdata, 32'h1008);
    w0 = n_wen;
    run_op(3'b000, 12'h7C0, 32'h5, 1'b1, 32'h0, 32'h0, 1'b0, 32'h0);
    chk("unimpl_wen", 64'(n_wen - w0), 64'd1);
    chk("unimpl_waddr", last_waddr, 12'h7C0);

    // Back-pressure: response must hold for 5 cycles
    begin
      exp_t e;
      e.rdata = 32'h1008; e.redir = 1'b0; e.target = 32'h0; e.lat = 3;
      q.push_back(e);
      pushes++;
    end
    resp_ready = 1'b0;
    issue(3'b001, 12'h300, 32'h0, 1'b1, 32'h0);
    repeat (2) begin @(posedge clk); #1; end
    for (int i = 0; i < 5; i++) begin
      chk("hold_resp_valid", resp_valid, 1'b1);
      chk("hold_req_ready", req_ready, 1'b0);
      chk("hold_resp_rdata", resp_rdata, 32'h1008);
      chk("hold_redirect", resp_redirect, 1'b0);
      @(posedge clk); #1;
    end
    resp_ready = 1'b1;
    wait_done();
    chk("hold_back_idle", req_ready, 1'b1);

    // Reset during WRITE of CSRRC
    w0 = n_wen;
    issue(3'b010, 12'h300, 32'h8, 1'b0, 32'h0);
    @(posedge clk); #1;
    rst = 1'b1;
    @(negedge clk);
    chk("rst_mid_wen", csr_wen, 1'b0);
    chk("rst_mid_req_ready", req_ready, 1'b1);
    @(posedge clk); #1;
    rst = 1'b0;
    repeat (4) begin @(posedge clk); #1; end
    chk("rst_abort_resp_valid", resp_valid, 1'b0);
    chk("rst_abort_req_ready", req_ready, 1'b1);
    chk("rst_abort_no_wen", 64'(n_wen - w0), 64'd0);
    chk("rst_abort_mstatus", m_mstatus, 32'h1008);
    run_op(3'b001, 12'h300, 32'h0, 1'b1, 32'h0, 32'h1008, 1'b0, 32'h0);

    $display("test done: total=%0d bad=%0d", n_checks, n_bad);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL global_timeout: got no finish expected finish");
    $display("test done: total=%0d bad=%0d", n_checks, n_bad + 1);
    $fatal(1);
  end

endmodule
